// File: rtl/voice_pkg.sv
// Shared types for the voice allocator.
//   VoiceState   : per-voice lifecycle (IDLE, HELD, RELEASING)
//   VoiceEntry   : one voice-table row {state, note, age}
//   VoiceCommand : channel-addressed command sent to the note controller
//   AllocState   : allocator FSM states
//   ScanCand     : running candidates collected while scanning the table
package voice_pkg;

  localparam int NUM_VOICES = 8;
  localparam int CH_W       = 3;
  localparam int AGE_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    RELEASING
  } VoiceState;

  typedef struct packed {
    VoiceState        state;
    logic [6:0]       note;
    logic [AGE_W-1:0] age;
  } VoiceEntry;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            on;
    logic [6:0]      note;
    logic [6:0]      vel;
    logic            steal;
  } VoiceCommand;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DECIDE,
    S_ISSUE
  } AllocState;

  typedef struct packed {
    logic             match_vld;
    logic [CH_W-1:0]  match_ch;
    logic             idle_vld;
    logic [CH_W-1:0]  idle_ch;
    logic             rel_vld;
    logic [CH_W-1:0]  rel_ch;
    logic [AGE_W-1:0] rel_age;
    logic             held_vld;
    logic [CH_W-1:0]  held_ch;
    logic [AGE_W-1:0] held_age;
  } ScanCand;

  // Age increment that sticks at all-ones instead of wrapping.
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + AGE_W'(1);
  endfunction

endpackage

// File: rtl/voice_scan_unit.sv
// Combinational candidate update for one voice-table entry.
// Ports:
//   vld_i   : entry_i/ch_i hold a real scan sample this cycle
//   entry_i : sampled voice entry, ch_i its channel index
//   on_i    : command is a note-on (0 = note-off)
//   note_i  : command note
//   cand_i  : candidates so far, cand_o candidates including this entry
// Entries arrive in increasing channel order, so "first wins" and
// "strictly older replaces" both resolve ties to the lowest index.
module voice_scan_unit
  import voice_pkg::*;
(
  input  logic            vld_i,
  input  VoiceEntry       entry_i,
  input  logic [CH_W-1:0] ch_i,
  input  logic            on_i,
  input  logic [6:0]      note_i,
  input  ScanCand         cand_i,
  output ScanCand         cand_o
);

  logic note_hit;

  // Note-on may retrigger a HELD or RELEASING voice; note-off only
  // releases a HELD one.
  always_comb begin
    note_hit = 1'b0;
    if (entry_i.note == note_i) begin
      note_hit = on_i ? (entry_i.state != IDLE) : (entry_i.state == HELD);
    end
  end

  always_comb begin
    cand_o = cand_i;
    if (vld_i) begin
      if (!cand_i.match_vld && note_hit) begin
        cand_o.match_vld = 1'b1;
        cand_o.match_ch  = ch_i;
      end
      if (!cand_i.idle_vld && entry_i.state == IDLE) begin
        cand_o.idle_vld = 1'b1;
        cand_o.idle_ch  = ch_i;
      end
      if (entry_i.state == RELEASING &&
          (!cand_i.rel_vld || entry_i.age > cand_i.rel_age)) begin
        cand_o.rel_vld = 1'b1;
        cand_o.rel_ch  = ch_i;
        cand_o.rel_age = entry_i.age;
      end
      if (entry_i.state == HELD &&
          (!cand_i.held_vld || entry_i.age > cand_i.held_age)) begin
        cand_o.held_vld = 1'b1;
        cand_o.held_ch  = ch_i;
        cand_o.held_age = entry_i.age;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: maps note-on/note-off events onto synthesizer channels.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   cmd_*_i / cmd_ready_o  : upstream command handshake (on, note, vel)
//   release_done_i         : per-voice pulse, envelope release finished
//   voice_*_o / voice_ready_i : issued channel command handshake
//   active_mask_o          : registered mask of non-IDLE voices
// The table is walked one voice per cycle: each cycle samples one entry
// into a snapshot register and the scan unit folds the previous snapshot
// into the candidate registers, so the decision is made on the state each
// voice had at its own sample cycle.
module voice_allocator
  import voice_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_on_i,
  input  logic [6:0]            cmd_note_i,
  input  logic [6:0]            cmd_vel_i,
  input  logic [NUM_VOICES-1:0] release_done_i,
  output logic                  voice_valid_o,
  input  logic                  voice_ready_i,
  output logic [CH_W-1:0]       voice_ch_o,
  output logic                  voice_on_o,
  output logic [6:0]            voice_note_o,
  output logic [6:0]            voice_vel_o,
  output logic                  voice_steal_o,
  output logic [NUM_VOICES-1:0] active_mask_o
);

  localparam logic [CH_W:0] IDX_END = (CH_W+1)'(NUM_VOICES);

  AllocState             state_q, state_d;
  logic [CH_W:0]         idx_q, idx_d;
  logic                  cmd_on_q, cmd_on_d;
  logic [6:0]            cmd_note_q, cmd_note_d;
  logic [6:0]            cmd_vel_q, cmd_vel_d;
  VoiceEntry             voices_q [NUM_VOICES];
  VoiceEntry             voices_d [NUM_VOICES];
  VoiceEntry             snap_q;
  logic [CH_W-1:0]       snap_ch_q;
  logic                  snap_vld_q;
  ScanCand               cand_q, cand_d, cand_scan;
  VoiceCommand           out_q, out_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [CH_W-1:0]       commit_ch;
  logic                  commit_steal;
  logic                  commit_drop;

  voice_scan_unit u_scan (
    .vld_i   (snap_vld_q),
    .entry_i (snap_q),
    .ch_i    (snap_ch_q),
    .on_i    (cmd_on_q),
    .note_i  (cmd_note_q),
    .cand_i  (cand_q),
    .cand_o  (cand_scan)
  );

  // Priority resolution from the final candidates.
  always_comb begin
    commit_ch    = '0;
    commit_steal = 1'b0;
    commit_drop  = 1'b0;
    if (cmd_on_q) begin
      if (cand_q.match_vld) begin
        commit_ch = cand_q.match_ch;
      end else if (cand_q.idle_vld) begin
        commit_ch = cand_q.idle_ch;
      end else if (cand_q.rel_vld) begin
        commit_ch = cand_q.rel_ch;
      end else if (cand_q.held_vld) begin
        commit_ch    = cand_q.held_ch;
        commit_steal = 1'b1;
      end
    end else begin
      commit_ch   = cand_q.match_ch;
      commit_drop = !cand_q.match_vld;
    end
  end

  // Voice table: release pulses apply first, then the commit overrides,
  // so a commit to a voice that is releasing in the same cycle wins.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      voices_d[i] = voices_q[i];
      if (release_done_i[i] && voices_q[i].state == RELEASING) begin
        voices_d[i].state = IDLE;
      end
    end
    if (state_q == S_DECIDE && !commit_drop) begin
      if (cmd_on_q) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (CH_W'(i) == commit_ch) begin
            voices_d[i] = '{state: HELD, note: cmd_note_q, age: '0};
          end else if (voices_d[i].state != IDLE) begin
            voices_d[i].age = age_inc(voices_d[i].age);
          end
        end
      end else begin
        voices_d[commit_ch].state = RELEASING;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_active
    assign active_d[gi] = (voices_d[gi].state != IDLE);
  end

  // Allocator FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cmd_on_d   = cmd_on_q;
    cmd_note_d = cmd_note_q;
    cmd_vel_d  = cmd_vel_q;
    cand_d     = snap_vld_q ? cand_scan : cand_q;
    out_d      = out_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d    = S_SCAN;
          idx_d      = '0;
          // A zero-velocity note-on is a note-off.
          cmd_on_d   = cmd_on_i && (cmd_vel_i != 7'd0);
          cmd_note_d = cmd_note_i;
          cmd_vel_d  = cmd_vel_i;
          cand_d     = '0;
        end
      end
      S_SCAN: begin
        // idx reaches IDX_END while the last snapshot is being folded in.
        if (idx_q == IDX_END) begin
          state_d = S_DECIDE;
        end else begin
          idx_d = idx_q + (CH_W+1)'(1);
        end
      end
      S_DECIDE: begin
        if (commit_drop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ISSUE;
          out_d   = '{ch: commit_ch, on: cmd_on_q, note: cmd_note_q,
                      vel: cmd_vel_q, steal: commit_steal};
        end
      end
      S_ISSUE: begin
        if (voice_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cmd_on_q   <= 1'b0;
      cmd_note_q <= '0;
      cmd_vel_q  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        voices_q[i] <= '{state: IDLE, note: '0, age: '0};
      end
      snap_q     <= '{state: IDLE, note: '0, age: '0};
      snap_ch_q  <= '0;
      snap_vld_q <= 1'b0;
      cand_q     <= '0;
      out_q      <= '0;
      active_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cmd_on_q   <= cmd_on_d;
      cmd_note_q <= cmd_note_d;
      cmd_vel_q  <= cmd_vel_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        voices_q[i] <= voices_d[i];
      end
      snap_q     <= voices_q[idx_q[CH_W-1:0]];
      snap_ch_q  <= idx_q[CH_W-1:0];
      snap_vld_q <= (state_q == S_SCAN) && !idx_q[CH_W];
      cand_q     <= cand_d;
      out_q      <= out_d;
      active_q   <= active_d;
    end
  end

  assign cmd_ready_o   = (state_q == S_IDLE) && rst_ni;
  assign voice_valid_o = (state_q == S_ISSUE);
  assign voice_ch_o    = out_q.ch;
  assign voice_on_o    = out_q.on;
  assign voice_note_o  = out_q.note;
  assign voice_vel_o   = out_q.vel;
  assign voice_steal_o = out_q.steal;
  assign active_mask_o = active_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed, table-driven bench for voice_allocator.
module tb_voice_allocator;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_on;
  logic [6:0] cmd_note;
  logic [6:0] cmd_vel;
  logic [7:0] release_done;
  logic       voice_valid;
  logic       voice_ready;
  logic [2:0] voice_ch;
  logic       voice_on;
  logic [6:0] voice_note;
  logic [6:0] voice_vel;
  logic       voice_steal;
  logic [7:0] active_mask;

  int n_vec = 0;
  int n_err = 0;

  voice_allocator dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_on_i       (cmd_on),
    .cmd_note_i     (cmd_note),
    .cmd_vel_i      (cmd_vel),
    .release_done_i (release_done),
    .voice_valid_o  (voice_valid),
    .voice_ready_i  (voice_ready),
    .voice_ch_o     (voice_ch),
    .voice_on_o     (voice_on),
    .voice_note_o   (voice_note),
    .voice_vel_o    (voice_vel),
    .voice_steal_o  (voice_steal),
    .active_mask_o  (active_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    logic       exp_issue;
    logic [2:0] exp_ch;
    logic       exp_on;
    logic       exp_steal;
    logic [7:0] exp_mask;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge. Waits for ready, presents one command,
  // then counts edges until it is either issued or dropped.
  task automatic do_cmd(input logic on, input logic [6:0] note, input logic [6:0] vel,
                        output logic issued, output int lat);
    int w;
    w = 0;
    while (!cmd_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_on    = on;
    cmd_note  = note;
    cmd_vel   = vel;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    issued = 1'b0;
    lat    = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (voice_valid) begin
        issued = 1'b1;
        lat    = k;
        break;
      end
      if (cmd_ready) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_issue();
    voice_ready = 1'b1;
    @(posedge clk); #1;
    voice_ready = 1'b0;
    chk("valid_drop", {31'd0, voice_valid}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic issued;
    int   lat;
    do_cmd(v.on, v.note, v.vel, issued, lat);
    chk("issued", {31'd0, issued}, {31'd0, v.exp_issue});
    chk("latency", lat, 32'd10);
    if (v.exp_issue) begin
      chk("ch",    {29'd0, voice_ch},    {29'd0, v.exp_ch});
      chk("on",    {31'd0, voice_on},    {31'd0, v.exp_on});
      chk("note",  {25'd0, voice_note},  {25'd0, v.note});
      chk("vel",   {25'd0, voice_vel},   {25'd0, v.vel});
      chk("steal", {31'd0, voice_steal}, {31'd0, v.exp_steal});
    end
    chk("mask", {24'd0, active_mask}, {24'd0, v.exp_mask});
    $display("vec %0d: on=%0d note=%0d vel=%0d -> issued=%0d lat=%0d ch=%0d on=%0d steal=%0d mask=%02h",
             id, v.on, v.note, v.vel, issued, lat, voice_ch, voice_on, voice_steal, active_mask);
    if (issued) finish_issue();
  endtask

  initial begin
    logic       issued;
    int         lat;
    logic [2:0] held_ch;
    logic [6:0] held_note;

    // {on, note, vel, issue, ch, on, steal, mask}
    vecs[0]  = '{1'b1, 7'd60, 7'd100, 1'b1, 3'd0, 1'b1, 1'b0, 8'h01};
    vecs[1]  = '{1'b1, 7'd61, 7'd100, 1'b1, 3'd1, 1'b1, 1'b0, 8'h03};
    vecs[2]  = '{1'b1, 7'd62, 7'd100, 1'b1, 3'd2, 1'b1, 1'b0, 8'h07};
    vecs[3]  = '{1'b1, 7'd63, 7'd100, 1'b1, 3'd3, 1'b1, 1'b0, 8'h0F};
    vecs[4]  = '{1'b1, 7'd64, 7'd100, 1'b1, 3'd4, 1'b1, 1'b0, 8'h1F};
    vecs[5]  = '{1'b1, 7'd65, 7'd100, 1'b1, 3'd5, 1'b1, 1'b0, 8'h3F};
    vecs[6]  = '{1'b1, 7'd66, 7'd100, 1'b1, 3'd6, 1'b1, 1'b0, 8'h7F};
    vecs[7]  = '{1'b1, 7'd67, 7'd100, 1'b1, 3'd7, 1'b1, 1'b0, 8'hFF};
    // all busy: ch0 is the oldest HELD voice -> steal
    vecs[8]  = '{1'b1, 7'd70, 7'd90,  1'b1, 3'd0, 1'b1, 1'b1, 8'hFF};
    // note-off 61 releases ch1
    vecs[9]  = '{1'b0, 7'd61, 7'd0,   1'b1, 3'd1, 1'b0, 1'b0, 8'hFF};
    // note-on of a held note retriggers its voice
    vecs[10] = '{1'b1, 7'd62, 7'd50,  1'b1, 3'd2, 1'b1, 1'b0, 8'hFF};
    // new note, no idle voice: the releasing ch1 is preferred, no steal
    vecs[11] = '{1'b1, 7'd80, 7'd40,  1'b1, 3'd1, 1'b1, 1'b0, 8'hFF};
    // note-off of a note never played is dropped
    vecs[12] = '{1'b0, 7'd55, 7'd0,   1'b0, 3'd0, 1'b0, 1'b0, 8'hFF};
    // zero-velocity note-on acts as note-off on ch4
    vecs[13] = '{1'b1, 7'd64, 7'd0,   1'b1, 3'd4, 1'b0, 1'b0, 8'hFF};
    // RELEASING match is not re-issued
    vecs[14] = '{1'b0, 7'd64, 7'd0,   1'b0, 3'd0, 1'b0, 1'b0, 8'hFF};
    // after ch4 finished its release it is the only idle voice
    vecs[15] = '{1'b1, 7'd90, 7'd70,  1'b1, 3'd4, 1'b1, 1'b0, 8'hFF};

    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_on       = 1'b0;
    cmd_note     = '0;
    cmd_vel      = '0;
    release_done = '0;
    voice_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mask",  {24'd0, active_mask}, 32'd0);
    chk("rst_valid", {31'd0, voice_valid}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready},   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_ch",    {29'd0, voice_ch},  32'd0);

    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        // ch4 is RELEASING, ch3 is HELD: only bit 4 may clear.
        release_done = 8'h18;
        @(posedge clk); #1;
        release_done = 8'h00;
        chk("release_mask", {24'd0, active_mask}, 32'h0000_00EF);
        $display("release pulse 0x18 -> mask=%02h", active_mask);
        @(posedge clk); #1;
        chk("release_mask_hold", {24'd0, active_mask}, 32'h0000_00EF);
      end
      run_vec(vecs[i], i);
    end

    // Downstream stall: outputs must hold while voice_ready is low.
    do_cmd(1'b1, 7'd90, 7'd20, issued, lat);
    chk("stall_issued", {31'd0, issued}, 32'd1);
    chk("stall_ch", {29'd0, voice_ch}, 32'd4);
    held_ch   = voice_ch;
    held_note = voice_note;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, voice_valid}, 32'd1);
      chk("stall_ch_hold", {29'd0, voice_ch}, {29'd0, held_ch});
      chk("stall_note_hold", {25'd0, voice_note}, {25'd0, held_note});
      chk("stall_ready", {31'd0, cmd_ready}, 32'd0);
    end
    $display("stall: ch=%0d note=%0d held 5 cycles", voice_ch, voice_note);
    finish_issue();

    // Reset in the middle of a scan drops the command and clears the table.
    cmd_valid = 1'b1;
    cmd_on    = 1'b1;
    cmd_note  = 7'd100;
    cmd_vel   = 7'd30;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, voice_valid}, 32'd0);
    chk("midrst_mask",  {24'd0, active_mask}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready},   32'd0);
    $display("mid-scan reset: valid=%0d mask=%02h", voice_valid, active_mask);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[0], 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Schedules note commands onto the 8 time-multiplexed channels of the polyphonic synthesizer.
- Accepts note-on/note-off events from an upstream command source and decides which channel (voice) each event targets.
- Tracks per-voice state and steals voices when all are busy.
- Emits one channel-addressed command per accepted event toward the note controller.

Parameters:
- NUM_VOICES, 8, number of synthesizer channels; must be a power of 2.
- CH_W, 3, channel index width, equal to log2(NUM_VOICES).
- AGE_W, 8, width of the per-voice allocation age counter.

Ports:
- CLK  in  1  block clock.
- RESET  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  upstream command valid.
- CMD_READY  out  1  block can accept a command.
- CMD_ON  in  1  1 = note-on, 0 = note-off.
- CMD_NOTE  in  7  note number.
- CMD_VEL  in  7  velocity.
- RELEASE_DONE  in  NUM_VOICES  per-voice pulse: envelope finished its release.
- VOICE_VALID  out  1  issued command valid.
- VOICE_READY  in  1  downstream accepts the issued command.
- VOICE_CH  out  CH_W  target channel.
- VOICE_ON  out  1  note-on / note-off.
- VOICE_NOTE  out  7  note number.
- VOICE_VEL  out  7  velocity.
- VOICE_STEAL  out  1  command replaces a held voice.
- ACTIVE_MASK  out  NUM_VOICES  voice i is not IDLE.

Behaviour:
- Reset (RESET low, asynchronous):
  - All voices IDLE, note 0, age 0.
  - FSM to S_IDLE; all outputs 0.
  - A pending or issuing command is dropped.
- CMD_READY = 1 only in S_IDLE with RESET high.
- Voice state per entry: IDLE, HELD, RELEASING. Each entry also stores note[6:0] and age[AGE_W-1:0].
- FSM states and transitions:
  - S_IDLE: on CMD_VALID && CMD_READY, capture CMD_* and go to S_SCAN with idx = 0.
  - S_SCAN: examine voice idx once per cycle and update the candidate registers; idx wraps to S_DECIDE after NUM_VOICES-1.
  - S_DECIDE: commit the voice table update. Go to S_ISSUE, or to S_IDLE if the note-off is unmatched.
  - S_ISSUE: VOICE_VALID = 1 and outputs held stable until VOICE_READY; then go to S_IDLE.
- Latency: accept at edge T gives VOICE_VALID high from T+NUM_VOICES+2 (T+10 at the default).
- Note-on with CMD_VEL = 0 is treated as note-off.
- Note-on priority (ties resolved to the lowest index):
  1. Voice (HELD or RELEASING) with the same note: retrigger, VOICE_STEAL = 0.
  2. Lowest-index IDLE voice.
  3. RELEASING voice with the largest age.
  4. HELD voice with the largest age: VOICE_STEAL = 1.
- On note-on commit:
  - The chosen voice becomes HELD with the new note and age 0.
  - Every other non-IDLE voice increments its age, saturating at all-ones.
- Note-off handling:
  - The HELD voice matching the note becomes RELEASING; issue a note-off on that channel.
  - No HELD match: drop the command (no VOICE_VALID) and return to S_IDLE.
  - A RELEASING match is not re-issued.
- RELEASE_DONE[i]:
  - Voice i goes RELEASING to IDLE in the next cycle.
  - Ignored for HELD or IDLE voices.
  - If it coincides with the S_DECIDE commit to voice i, the commit wins (voice becomes HELD).
- The scan uses the state seen at each voice's scan cycle. A voice freed after its scan cycle is not reconsidered.
- ACTIVE_MASK is registered and reflects the table after each commit or release.

Decomposition:
- Package voice_pkg holds:
  - enum VoiceState {IDLE, HELD, RELEASING}
  - struct VoiceEntry {state, note, age}
  - struct VoiceCommand {ch, on, note, vel, steal}
  - enum AllocState {S_IDLE, S_SCAN, S_DECIDE, S_ISSUE}
- Sub-module voice_scan_unit: per-cycle candidate comparison (match, first idle, oldest releasing, oldest held). It is registered inside the allocator FSM.

Test Plan:
1. After reset, note-on 60 vel 100 → VOICE_CH = 0, VOICE_ON = 1, STEAL = 0, 10 cycles after accept; ACTIVE_MASK = 8'h01.
2. Note-ons 60..67 (8 notes), then note-on 70 → CH = 0 (oldest HELD), STEAL = 1.
3. Note-on 60, note-off 60, then note-on 62 with all other voices HELD → CH = 0 (releasing preferred), STEAL = 0.
4. Note-off 55 never played → no VOICE_VALID; CMD_READY high again 10 cycles after accept.
5. Note-off 60 on ch 0 with RELEASE_DONE[0] pulse → ACTIVE_MASK bit 0 clears next cycle. Note-on 64 with vel 0 → handled as note-off.
6. Hold VOICE_READY = 0 for 5 cycles in S_ISSUE → outputs stable, CMD_READY = 0. Assert RESET low mid-scan → VOICE_VALID = 0, ACTIVE_MASK = 0, and the next command goes to ch 0.
